// File: rtl/fetch_stage.sv
// Y86-64 fetch stage: byte-addressed instruction memory, field decode, valP/predPC,
// plus the F (predicted PC) and D pipeline registers with stall/bubble control.
module fetch_stage #(
    parameter int unsigned IMEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] PC_new,
    input  logic        F_stall,
    input  logic        D_stall,
    input  logic        D_bubble,
    input  logic        im_we,
    input  logic [63:0] im_waddr,
    input  logic [7:0]  im_wdata,
    output logic [63:0] F_predPC,
    output logic [2:0]  D_stat,
    output logic [3:0]  D_icode,
    output logic [3:0]  D_ifun,
    output logic [3:0]  D_rA,
    output logic [3:0]  D_rB,
    output logic [63:0] D_valC,
    output logic [63:0] D_valP
);

    localparam int unsigned AW = $clog2(IMEM_BYTES);

    localparam logic [2:0] StatAok = 3'd1;
    localparam logic [2:0] StatHlt = 3'd2;
    localparam logic [2:0] StatAdr = 3'd3;
    localparam logic [2:0] StatIns = 3'd4;

    typedef struct packed {
        logic [2:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } d_reg_t;

    localparam d_reg_t Bubble = '{
        stat: StatAok, icode: 4'h1, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0
    };

    logic [7:0]  mem_q [IMEM_BYTES];
    logic [7:0]  fb [10];
    logic [63:0] byte_addr;
    logic [3:0]  icode_raw;
    logic [3:0]  len;
    logic        adr;
    logic [63:0] f_pred_pc;
    logic [63:0] f_pred_pc_q;
    d_reg_t      dec;
    d_reg_t      d_d;
    d_reg_t      d_q;

    always_ff @(posedge clk) begin
        if (im_we && (im_waddr < 64'(IMEM_BYTES))) begin
            mem_q[im_waddr[AW-1:0]] <= im_wdata;
        end
    end

    // Bytes past the end of memory read as zero; any such fetch is flagged ADR anyway.
    always_comb begin
        byte_addr = 64'd0;
        for (int i = 0; i < 10; i++) begin
            byte_addr = PC_new + 64'(i);
            fb[i]     = 8'h00;
            if (byte_addr < 64'(IMEM_BYTES)) begin
                fb[i] = mem_q[byte_addr[AW-1:0]];
            end
        end
    end

    always_comb begin
        icode_raw = fb[0][7:4];
        case (icode_raw)
            4'h2, 4'h6, 4'hA, 4'hB: len = 4'd2;
            4'h7, 4'h8:             len = 4'd9;
            4'h3, 4'h4, 4'h5:       len = 4'd10;
            default:                len = 4'd1;
        endcase

        dec.icode = icode_raw;
        dec.ifun  = fb[0][3:0];
        dec.ra    = 4'hF;
        dec.rb    = 4'hF;
        dec.valc  = 64'd0;
        dec.valp  = PC_new + {60'd0, len};
        if (len == 4'd2 || len == 4'd10) begin
            dec.ra = fb[1][7:4];
            dec.rb = fb[1][3:0];
        end
        if (len == 4'd10) begin
            dec.valc = {fb[9], fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2]};
        end else if (len == 4'd9) begin
            dec.valc = {fb[8], fb[7], fb[6], fb[5], fb[4], fb[3], fb[2], fb[1]};
        end

        // No wrap in this compare: any PC at or beyond the memory end is ADR.
        adr = PC_new > (64'(IMEM_BYTES) - {60'd0, len});
        if (adr) begin
            dec.stat  = StatAdr;
            dec.icode = 4'h1;
            dec.ifun  = 4'h0;
            dec.ra    = 4'hF;
            dec.rb    = 4'hF;
            dec.valc  = 64'd0;
        end else if (icode_raw > 4'hB) begin
            dec.stat = StatIns;
        end else if (icode_raw == 4'h0) begin
            dec.stat = StatHlt;
        end else begin
            dec.stat = StatAok;
        end

        f_pred_pc = (dec.icode == 4'h7 || dec.icode == 4'h8) ? dec.valc : dec.valp;
    end

    always_comb begin
        d_d = d_q;
        if (D_bubble) begin
            d_d = Bubble;
        end else if (!D_stall) begin
            d_d = dec;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            f_pred_pc_q <= 64'd0;
            d_q         <= Bubble;
        end else begin
            if (!F_stall) begin
                f_pred_pc_q <= f_pred_pc;
            end
            d_q <= d_d;
        end
    end

    assign F_predPC = f_pred_pc_q;
    assign D_stat   = d_q.stat;
    assign D_icode  = d_q.icode;
    assign D_ifun   = d_q.ifun;
    assign D_rA     = d_q.ra;
    assign D_rB     = d_q.rb;
    assign D_valC   = d_q.valc;
    assign D_valP   = d_q.valp;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage with hand-computed expected values.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] PC_new;
    logic        F_stall, D_stall, D_bubble;
    logic        im_we;
    logic [63:0] im_waddr;
    logic [7:0]  im_wdata;
    logic [63:0] F_predPC;
    logic [2:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;

    int checks = 0;
    int errors = 0;

    fetch_stage #(.IMEM_BYTES(1024)) dut (
        .clk      (clk),
        .reset    (reset),
        .PC_new   (PC_new),
        .F_stall  (F_stall),
        .D_stall  (D_stall),
        .D_bubble (D_bubble),
        .im_we    (im_we),
        .im_waddr (im_waddr),
        .im_wdata (im_wdata),
        .F_predPC (F_predPC),
        .D_stat   (D_stat),
        .D_icode  (D_icode),
        .D_ifun   (D_ifun),
        .D_rA     (D_rA),
        .D_rB     (D_rB),
        .D_valC   (D_valC),
        .D_valP   (D_valP)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [63:0] addr, input logic [7:0] data);
        im_we    = 1'b1;
        im_waddr = addr;
        im_wdata = data;
        tick();
        im_we    = 1'b0;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".stat"},  64'(D_stat),  64'd1);
        chk({tag, ".icode"}, 64'(D_icode), 64'd1);
        chk({tag, ".ifun"},  64'(D_ifun),  64'd0);
        chk({tag, ".rA"},    64'(D_rA),    64'hF);
        chk({tag, ".rB"},    64'(D_rB),    64'hF);
        chk({tag, ".valC"},  D_valC,       64'd0);
        chk({tag, ".valP"},  D_valP,       64'd0);
    endtask

    logic [7:0] irmovq [10];
    logic [7:0] jxx [9];

    initial begin
        irmovq = '{8'h30, 8'hF2, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        jxx    = '{8'h70, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        PC_new = 64'd0;
        im_we = 1'b0; im_waddr = 64'd0; im_wdata = 8'd0;

        // Reset wins over stall and bubble.
        reset = 1'b1; F_stall = 1'b1; D_stall = 1'b1; D_bubble = 1'b1;
        tick();
        chk("rst.predPC", F_predPC, 64'd0);
        chk_bubble("rst");
        reset = 1'b0; F_stall = 1'b0; D_stall = 1'b0; D_bubble = 1'b0;

        // irmovq at 0x10
        for (int i = 0; i < 10; i++) write_byte(64'h10 + 64'(i), irmovq[i]);
        PC_new = 64'h10;
        tick();
        chk("irm.stat",   64'(D_stat),  64'd1);
        chk("irm.icode",  64'(D_icode), 64'd3);
        chk("irm.ifun",   64'(D_ifun),  64'd0);
        chk("irm.rA",     64'(D_rA),    64'hF);
        chk("irm.rB",     64'(D_rB),    64'h2);
        chk("irm.valC",   D_valC,       64'h0102030405060708);
        chk("irm.valP",   D_valP,       64'h1A);
        chk("irm.predPC", F_predPC,     64'h1A);

        // jXX at 0
        for (int i = 0; i < 9; i++) write_byte(64'(i), jxx[i]);
        PC_new = 64'h0;
        tick();
        chk("jxx.icode",  64'(D_icode), 64'd7);
        chk("jxx.rA",     64'(D_rA),    64'hF);
        chk("jxx.valC",   D_valC,       64'h100);
        chk("jxx.valP",   D_valP,       64'd9);
        chk("jxx.predPC", F_predPC,     64'h100);

        // Invalid icode and halt
        write_byte(64'h30, 8'hC0);
        write_byte(64'h31, 8'h00);
        PC_new = 64'h30;
        tick();
        chk("ins.stat",  64'(D_stat),  64'd4);
        chk("ins.icode", 64'(D_icode), 64'hC);
        chk("ins.valP",  D_valP,       64'h31);
        PC_new = 64'h31;
        tick();
        chk("hlt.stat",  64'(D_stat),  64'd2);
        chk("hlt.icode", 64'(D_icode), 64'd0);
        chk("hlt.valP",  D_valP,       64'h32);

        // irmovq straddling the end of memory
        for (int i = 0; i < 5; i++) write_byte(64'd1019 + 64'(i), irmovq[i]);
        PC_new = 64'd1019;
        tick();
        chk("adr.stat",   64'(D_stat),  64'd3);
        chk("adr.icode",  64'(D_icode), 64'd1);
        chk("adr.rA",     64'(D_rA),    64'hF);
        chk("adr.valC",   D_valC,       64'd0);
        chk("adr.valP",   D_valP,       64'd1029);
        chk("adr.predPC", F_predPC,     64'd1029);
        PC_new = 64'd1024;
        tick();
        chk("adr1024.stat", 64'(D_stat), 64'd3);
        chk("adr1024.valP", D_valP,      64'd1025);
        PC_new = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        chk("wrap.stat",   64'(D_stat), 64'd3);
        chk("wrap.valP",   D_valP,      64'd0);
        chk("wrap.predPC", F_predPC,    64'd0);

        // rrmovq then D_stall held while PC_new changes
        write_byte(64'h40, 8'h20);
        write_byte(64'h41, 8'h12);
        PC_new = 64'h40;
        tick();
        chk("rr.icode", 64'(D_icode), 64'd2);
        chk("rr.rA",    64'(D_rA),    64'h1);
        chk("rr.rB",    64'(D_rB),    64'h2);
        chk("rr.valP",  D_valP,       64'h42);
        D_stall = 1'b1;
        PC_new = 64'h10; tick();
        chk("stall1.rA", 64'(D_rA), 64'h1);
        chk("stall1.rB", 64'(D_rB), 64'h2);
        PC_new = 64'h0; tick();
        chk("stall2.icode", 64'(D_icode), 64'd2);
        chk("stall2.valP",  D_valP,       64'h42);
        PC_new = 64'h30; tick();
        chk("stall3.rA",     64'(D_rA),  64'h1);
        chk("stall3.rB",     64'(D_rB),  64'h2);
        chk("stall3.valC",   D_valC,     64'd0);
        chk("stall3.predPC", F_predPC,   64'h31);

        // Bubble beats stall
        D_bubble = 1'b1;
        tick();
        chk_bubble("bub");
        D_bubble = 1'b0; D_stall = 1'b0;

        // F_stall holds predicted PC while D keeps loading
        F_stall = 1'b1;
        PC_new = 64'h10;
        tick(); tick(); tick();
        chk("fstall.predPC", F_predPC,     64'h31);
        chk("fstall.icode",  64'(D_icode), 64'd3);
        F_stall = 1'b0;

        // Same-edge write/read: fetch sees the old byte
        write_byte(64'h0, 8'h00);
        PC_new = 64'h0;
        im_we = 1'b1; im_waddr = 64'h0; im_wdata = 8'h10;
        tick();
        im_we = 1'b0;
        chk("coll.stat",  64'(D_stat),  64'd2);
        chk("coll.icode", 64'(D_icode), 64'd0);
        tick();
        chk("coll2.stat",  64'(D_stat),  64'd1);
        chk("coll2.icode", 64'(D_icode), 64'd1);
        chk("coll2.valP",  D_valP,       64'd1);

        // Mid-program reset clears registers, memory survives
        PC_new = 64'h10;
        reset = 1'b1;
        tick();
        chk("rst2.predPC", F_predPC, 64'd0);
        chk_bubble("rst2");
        reset = 1'b0;
        tick();
        chk("post.icode", 64'(D_icode), 64'd3);
        chk("post.valC",  D_valC,       64'h0102030405060708);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
